// File: rtl/display_source_sel.sv
// Display bus source selector: highest-index request wins, the chosen source
// lingers after requests drop, and an optional blink blanks non-default sources.
module display_source_sel #(
  parameter int WIDTH       = 16,
  parameter int NCH         = 3,
  parameter int DEFAULT_CH  = 0,
  parameter int HOLD_CYCLES = 1000,
  parameter int BLINK_HALF  = 500
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         show,
  input  logic [NCH*WIDTH-1:0]   x,
  input  logic                   blink_en,
  output logic [WIDTH-1:0]       y,
  output logic [$clog2(NCH)-1:0] sel,
  output logic                   active,
  output logic                   blank
);

  localparam int SW = $clog2(NCH);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int PW = $clog2(2 * BLINK_HALF);

  localparam logic [SW-1:0] DEF_SEL   = SW'(DEFAULT_CH);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(2 * BLINK_HALF - 1);
  localparam logic [PW-1:0] PH_BLANK  = PW'(BLINK_HALF);

  typedef enum logic [1:0] {
    ST_DEFAULT = 2'd0,
    ST_SHOW    = 2'd1,
    ST_LINGER  = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [SW-1:0]   sel_r, sel_s, req_idx_s;
  logic [HW-1:0]   lin_cnt_r, lin_cnt_s;
  logic [PW-1:0]   phase_r, phase_s;
  logic [WIDTH-1:0] y_r, y_s;
  logic            blank_r, blank_s, active_r, active_s, req_s;

  // Priority encode requests; the default source never counts as a request.
  always_comb begin
    req_s     = 1'b0;
    req_idx_s = DEF_SEL;
    for (int i = 0; i < NCH; i++) begin
      req_idx_s = (show[i] && (i != DEFAULT_CH)) ? SW'(i) : req_idx_s;
      req_s     = req_s | (show[i] && (i != DEFAULT_CH));
    end
  end

  // Next state, selected source and linger countdown.
  always_comb begin
    state_s   = state_r;
    sel_s     = sel_r;
    lin_cnt_s = lin_cnt_r;
    case (state_r)
      ST_DEFAULT: begin
        if (req_s) begin
          state_s = ST_SHOW;
          sel_s   = req_idx_s;
        end else begin
          sel_s   = DEF_SEL;
        end
      end
      ST_SHOW: begin
        if (req_s) begin
          sel_s     = req_idx_s;
        end else begin
          state_s   = ST_LINGER;
          lin_cnt_s = HOLD_LOAD;
        end
      end
      ST_LINGER: begin
        if (req_s) begin
          state_s   = ST_SHOW;
          sel_s     = req_idx_s;
          lin_cnt_s = {HW{1'b0}};
        end else if (lin_cnt_r == {HW{1'b0}}) begin
          state_s   = ST_DEFAULT;
          sel_s     = DEF_SEL;
        end else begin
          lin_cnt_s = lin_cnt_r - HW'(1);
        end
      end
      default: begin
        state_s   = ST_DEFAULT;
        sel_s     = DEF_SEL;
        lin_cnt_s = {HW{1'b0}};
      end
    endcase
  end

  // Blink phase restarts on a fresh selection but runs on across LINGER->SHOW.
  always_comb begin
    phase_s = {PW{1'b0}};
    if ((state_s == ST_DEFAULT) || !blink_en || (state_r == ST_DEFAULT)) begin
      phase_s = {PW{1'b0}};
    end else if (phase_r == PH_LAST) begin
      phase_s = {PW{1'b0}};
    end else begin
      phase_s = phase_r + PW'(1);
    end
    active_s = (state_s != ST_DEFAULT);
    blank_s  = active_s && blink_en && (phase_s >= PH_BLANK);
    y_s      = blank_s ? {WIDTH{1'b0}} : x[int'(sel_s) * WIDTH +: WIDTH];
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_DEFAULT;
      sel_r     <= DEF_SEL;
      lin_cnt_r <= {HW{1'b0}};
      phase_r   <= {PW{1'b0}};
      y_r       <= {WIDTH{1'b0}};
      blank_r   <= 1'b0;
      active_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      sel_r     <= sel_s;
      lin_cnt_r <= lin_cnt_s;
      phase_r   <= phase_s;
      y_r       <= y_s;
      blank_r   <= blank_s;
      active_r  <= active_s;
    end
  end

  assign y      = y_r;
  assign sel    = sel_r;
  assign active = active_r;
  assign blank  = blank_r;

endmodule

// File: tb/tb_display_source_sel.sv
// Randomized and directed bench for display_source_sel, checked against a
// model that tracks the shown channel and idle run length rather than FSM states.
module tb_display_source_sel;

  localparam int WIDTH = 16;
  localparam int NCH   = 3;
  localparam int DEF   = 0;
  localparam int HOLD  = 4;
  localparam int BH    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NCH-1:0]       show = '0;
  logic [NCH*WIDTH-1:0] x;
  logic                 blink_en = 1'b0;
  logic [WIDTH-1:0]     y;
  logic [1:0]           sel;
  logic                 active, blank;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: shown channel, cycles since last request, blink phase.
  int          m_ch = DEF;
  int          m_idle = 0;
  int          m_phase = 0;
  logic [15:0] e_y = 16'h0000;
  logic        e_blank = 1'b0;

  display_source_sel #(
    .WIDTH(WIDTH), .NCH(NCH), .DEFAULT_CH(DEF),
    .HOLD_CYCLES(HOLD), .BLINK_HALF(BH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .show(show), .x(x), .blink_en(blink_en),
    .y(y), .sel(sel), .active(active), .blank(blank)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ch = DEF; m_idle = 0; m_phase = 0; e_y = 16'h0000; e_blank = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs now applied.
  task automatic model_edge();
    int  r;
    bit  fresh;
    r = -1;
    fresh = 1'b0;
    for (int i = 0; i < NCH; i++) if (show[i] && i != DEF) r = i;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (r >= 0) begin
      fresh  = (m_ch == DEF);
      m_ch   = r;
      m_idle = 0;
    end else if (m_ch != DEF) begin
      m_idle++;
      if (m_idle > HOLD) begin m_ch = DEF; m_idle = 0; end
    end
    if (m_ch != DEF && blink_en) m_phase = fresh ? 0 : (m_phase + 1) % (2 * BH);
    else m_phase = 0;
    e_blank = (m_ch != DEF) && blink_en && (m_phase >= BH);
    e_y     = e_blank ? 16'h0000 : x[m_ch*WIDTH +: WIDTH];
  endtask

  task automatic check_all();
    check("y", 32'(y), 32'(e_y));
    check("sel", 32'(sel), 32'(m_ch));
    check("active", 32'(active), 32'(m_ch != DEF));
    check("blank", 32'(blank), 32'(e_blank));
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int n;
    bit found;
    x = {16'h5555, 16'hAAAA, 16'h1234};
    #12;
    check("rst_y", 32'(y), 32'h0);
    cycle();
    rst_n = 1'b1;
    cycle();
    check("idle_y", 32'(y), 32'h1234);

    // Single-cycle request: one SHOW cycle plus HOLD linger cycles.
    show = 3'b010;
    cycle();
    show = 3'b000;
    n = 1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (y == 16'hAAAA) n++;
    end
    check("linger_len", 32'(n), 32'(HOLD + 1));

    // Priority and live source value.
    show = 3'b110; cycle();
    check("prio_y", 32'(y), 32'h5555);
    show = 3'b010; cycle();
    check("drop_sel", 32'(sel), 32'd1);
    x[31:16] = 16'h0F0F; cycle();
    check("live_y", 32'(y), 32'h0F0F);

    // Re-request during linger restarts the full linger afterwards.
    show = 3'b000;
    for (int i = 0; i < 3; i++) cycle();
    show = 3'b100; cycle();
    show = 3'b000;
    for (int i = 0; i < 7; i++) cycle();

    // Blink pattern, then drop blink_en mid-blank.
    blink_en = 1'b1; show = 3'b100;
    for (int i = 0; i < 7; i++) cycle();
    check("mid_blank", 32'(blank), 32'd1);
    blink_en = 1'b0; cycle();
    check("unblank_y", 32'(y), 32'h5555);

    // Async reset while lingering and blanked.
    blink_en = 1'b1; show = 3'b000;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle();
      found = (m_ch != DEF) && (m_idle > 0) && e_blank;
    end
    check("find_linger_blank", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_y", 32'(y), 32'h0);
    check("arst_sel", 32'(sel), 32'd0);
    check("arst_active", 32'(active), 32'd0);
    check("arst_blank", 32'(blank), 32'd0);
    model_reset();
    cycle();
    rst_n = 1'b1; blink_en = 1'b0;
    cycle();
    check("rel_y", 32'(y), 32'(x[15:0]));

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      show = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      if ($urandom_range(0, 15) == 0) blink_en = ~blink_en;
      if ($urandom_range(0, 7) == 0) x = {16'($urandom), 16'($urandom), 16'($urandom)};
      rst_n = ($urandom_range(0, 99) != 0);
      if (!rst_n) begin
        #1;
        model_reset();
        check_all();
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
